// File: rtl/jtbubl_pkg.sv
// Shared definitions for the main-CPU side of the main<->sound mailbox.
package jtbubl_pkg;

   localparam logic [1:0] SNDIF_CMD  = 2'd0;
   localparam logic [1:0] SNDIF_STAT = 2'd1;
   localparam logic [1:0] SNDIF_RST  = 2'd2;
   localparam logic [1:0] SNDIF_IRQ  = 2'd3;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } sndif_state_t;

endpackage

// File: rtl/jtbubl_main_sndif_if.sv
// CPU-bus and sound-side signals of the mailbox; slave = mailbox, master = CPU/sound side.
interface jtbubl_main_sndif_if;
   logic       cen;
   logic       cs;
   logic [1:0] addr;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] cpu_dout;
   logic [7:0] dout;
   logic [7:0] snd_latch;
   logic       snd_stb;
   logic       snd_flag;
   logic [7:0] main_latch;
   logic       main_stb;
   logic       main_flag;
   logic       irq_n;
   logic       rstn;

   modport slave (
      input  cen, cs, addr, wr_n, rd_n, cpu_dout, snd_flag, main_latch, main_stb,
      output dout, snd_latch, snd_stb, main_flag, irq_n, rstn
   );

   modport master (
      output cen, cs, addr, wr_n, rd_n, cpu_dout, snd_flag, main_latch, main_stb,
      input  dout, snd_latch, snd_stb, main_flag, irq_n, rstn
   );
endinterface

// File: rtl/jtbubl_sndif_fifo.sv
// Small synchronous FIFO for sound-CPU reply bytes; caller guarantees no push when full
// (unless popping) and no pop when empty.
module jtbubl_sndif_fifo #(
   parameter int unsigned AW = 2,
   parameter int unsigned DW = 8
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_empty,
   output logic          o_full,
   output logic [AW:0]   o_cnt
);
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CW    = AW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wp] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + AW'(1);
         if (i_pop)  r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_data  = r_mem[r_rp];
   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_cnt   = r_cnt;
endmodule

// File: rtl/jtbubl_main_sndif.sv
// Main-CPU end of the main<->sound mailbox: command latch, reply capture and sound reset sequencer.
// Define JTBUBL_SNDFIFO_EN for a 2**FIFO_AW deep reply FIFO instead of a single reply register.
module jtbubl_main_sndif
   import jtbubl_pkg::*;
#(
   parameter int unsigned RST_HOLD = 16,
   parameter int unsigned FIFO_AW  = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   jtbubl_main_sndif_if.slave   bus
);
   localparam int unsigned CNT_W = FIFO_AW + 1;
   localparam int unsigned CW    = $clog2(RST_HOLD + 1);

   sndif_state_t  r_state;
   logic [CW-1:0] r_count;
   logic          r_rstn;
   logic          r_wr_prev, r_rd_prev, r_stb_prev;
   logic [7:0]    r_snd_latch, r_dout;
   logic          r_snd_stb, r_main_flag, r_irq_n, r_irq_en, r_ovf;

   logic             w_wr, w_rd, w_wr_acc, w_rd_acc;
   logic             w_hold_req, w_rel_req, w_flush;
   logic             w_push, w_push_ok, w_pop, w_ovf_set;
   logic             w_full, w_empty, w_flag_nxt, w_irq_en_nxt, w_stat_rd;
   logic [CNT_W-1:0] w_cnt, w_cnt_nxt;
   logic [7:0]       w_head;

   // Each access acts once, on the first clock its strobe is seen low
   assign w_wr     = bus.cs & ~bus.wr_n;
   assign w_rd     = bus.cs & ~bus.rd_n;
   assign w_wr_acc = w_wr & ~r_wr_prev;
   assign w_rd_acc = w_rd & ~r_rd_prev;

   assign w_hold_req = w_wr_acc && (bus.addr == SNDIF_RST) && !bus.cpu_dout[0];
   assign w_rel_req  = w_wr_acc && (bus.addr == SNDIF_RST) &&  bus.cpu_dout[0];
   assign w_stat_rd  = w_rd_acc && (bus.addr == SNDIF_STAT);
   assign w_irq_en_nxt = (w_wr_acc && (bus.addr == SNDIF_IRQ)) ? bus.cpu_dout[0] : r_irq_en;

   // The reply path is held empty while the sound CPU is in reset
   assign w_flush   = ~r_rstn | w_hold_req;
   assign w_push    = bus.main_stb & ~r_stb_prev & ~w_flush;
   assign w_pop     = w_rd_acc && (bus.addr == SNDIF_CMD) && !w_empty && !w_flush;
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_ovf_set = w_push & w_full & ~w_pop;
   assign w_cnt_nxt = w_flush ? '0 : (w_cnt + CNT_W'(w_push_ok) - CNT_W'(w_pop));
   assign w_flag_nxt = (w_cnt_nxt != '0);

`ifdef JTBUBL_SNDFIFO_EN
   jtbubl_sndif_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push_ok),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (bus.main_latch),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_cnt   (w_cnt)
   );
`else
   logic [7:0] r_reply;
   logic       r_valid;

   // Single reply slot: an unread reply is overwritten by a newer one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reply <= 8'h00;
         r_valid <= 1'b0;
      end else begin
         if (w_push) r_reply <= bus.main_latch;
         r_valid <= w_flag_nxt;
      end
   end

   assign w_head  = r_reply;
   assign w_empty = ~r_valid;
   assign w_full  = r_valid;
   assign w_cnt   = CNT_W'(r_valid);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= HOLD;
         r_count     <= CW'(RST_HOLD);
         r_rstn      <= 1'b0;
         r_wr_prev   <= 1'b0;
         r_rd_prev   <= 1'b0;
         r_stb_prev  <= 1'b0;
         r_snd_latch <= 8'h00;
         r_snd_stb   <= 1'b0;
         r_dout      <= 8'hff;
         r_main_flag <= 1'b0;
         r_irq_en    <= 1'b0;
         r_irq_n     <= 1'b1;
         r_ovf       <= 1'b0;
      end else begin
         r_wr_prev   <= w_wr;
         r_rd_prev   <= w_rd;
         r_stb_prev  <= bus.main_stb;
         r_snd_stb   <= 1'b0;
         r_irq_en    <= w_irq_en_nxt;
         r_main_flag <= w_flag_nxt;
         r_irq_n     <= ~(w_flag_nxt & w_irq_en_nxt);
         r_ovf       <= (r_ovf & ~w_stat_rd) | w_ovf_set;

         if (w_wr_acc && (bus.addr == SNDIF_CMD)) begin
            r_snd_latch <= bus.cpu_dout;
            r_snd_stb   <= 1'b1;
         end

         if (w_rd_acc) begin
            case (bus.addr)
               SNDIF_CMD:  r_dout <= w_pop ? w_head : 8'hff;
               SNDIF_STAT: r_dout <= {r_ovf, 5'h1f, ~bus.snd_flag, r_main_flag};
               default:    r_dout <= 8'hff;
            endcase
         end

         // Sound reset sequencer
         case (r_state)
            HOLD: begin
               if (w_rel_req) begin
                  r_state <= RELEASE;
                  r_count <= CW'(RST_HOLD);
               end
            end
            RELEASE: begin
               if (w_hold_req) begin
                  r_state <= HOLD;
               end else if (bus.cen) begin
                  r_count <= r_count - CW'(1);
                  if (r_count == CW'(1)) begin
                     r_state <= RUN;
                     r_rstn  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_hold_req) begin
                  r_state <= HOLD;
                  r_rstn  <= 1'b0;
               end
            end
            default: begin
               r_state <= HOLD;
               r_rstn  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dout      = r_dout;
   assign bus.snd_latch = r_snd_latch;
   assign bus.snd_stb   = r_snd_stb;
   assign bus.main_flag = r_main_flag;
   assign bus.irq_n     = r_irq_n;
   assign bus.rstn      = r_rstn;
endmodule

// File: tb/tb_jtbubl_main_sndif.sv
// Bench for jtbubl_main_sndif: directed scenarios plus random traffic against a queue-based model.
module tb_jtbubl_main_sndif;
   import jtbubl_pkg::*;

   localparam int RST_HOLD = 16;
`ifdef JTBUBL_SNDFIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   localparam int P_HOLD = 0, P_REL = 1, P_RUN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   jtbubl_main_sndif_if bus ();

   jtbubl_main_sndif #(.RST_HOLD(RST_HOLD), .FIFO_AW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int stb_cnt  = 0;
   logic chk_en = 1'b0;

   // Model state
   logic [7:0] q[$];
   logic m_ovf, m_irq_en, m_rstn, m_wr_prev, m_rd_prev, m_stb_prev;
   int   m_phase, m_left;
   logic [7:0] exp_dout, exp_latch;
   logic exp_stb, exp_flag, exp_irq_n;
   logic t_wr, t_rd, t_wacc, t_racc, t_rise, t_hold, t_rel, t_flush;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model, evaluated on the same edge the DUT samples
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         q.delete();
         m_ovf = 0; m_irq_en = 0; m_rstn = 0; m_phase = P_HOLD; m_left = RST_HOLD;
         m_wr_prev = 0; m_rd_prev = 0; m_stb_prev = 0;
         exp_dout = 8'hff; exp_latch = 8'h00; exp_stb = 0; exp_flag = 0; exp_irq_n = 1;
      end else begin
         t_wr   = bus.cs & ~bus.wr_n;
         t_rd   = bus.cs & ~bus.rd_n;
         t_wacc = t_wr & ~m_wr_prev;
         t_racc = t_rd & ~m_rd_prev;
         t_rise = bus.main_stb & ~m_stb_prev;
         t_hold = t_wacc && bus.addr == 2'd2 && !bus.cpu_dout[0];
         t_rel  = t_wacc && bus.addr == 2'd2 &&  bus.cpu_dout[0];
         t_flush = !m_rstn || t_hold;
         exp_stb = 0;
         if (t_racc) begin
            if (bus.addr == 2'd0) begin
               if (!t_flush && q.size() > 0) exp_dout = q.pop_front();
               else exp_dout = 8'hff;
            end else if (bus.addr == 2'd1) begin
               exp_dout = {m_ovf, 5'h1f, ~bus.snd_flag, q.size() != 0};
               m_ovf = 0;
            end else exp_dout = 8'hff;
         end
         if (t_flush) q.delete();
         else if (t_rise) begin
            if (q.size() < DEPTH) q.push_back(bus.main_latch);
            else begin
               m_ovf = 1;
`ifndef JTBUBL_SNDFIFO_EN
               q[0] = bus.main_latch;
`endif
            end
         end
         if (t_wacc && bus.addr == 2'd0) begin exp_latch = bus.cpu_dout; exp_stb = 1; end
         if (t_wacc && bus.addr == 2'd3) m_irq_en = bus.cpu_dout[0];
         if (t_hold) begin
            m_phase = P_HOLD; m_rstn = 0;
         end else if (m_phase == P_HOLD) begin
            if (t_rel) begin m_phase = P_REL; m_left = RST_HOLD; end
         end else if (m_phase == P_REL && bus.cen) begin
            m_left--;
            if (m_left == 0) begin m_phase = P_RUN; m_rstn = 1; end
         end
         exp_flag  = q.size() != 0;
         exp_irq_n = !(exp_flag && m_irq_en);
         m_wr_prev = t_wr; m_rd_prev = t_rd; m_stb_prev = bus.main_stb;
      end
   end

   // Per-cycle comparison of every output against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("dout",      32'(bus.dout),      32'(exp_dout));
         chk("snd_latch", 32'(bus.snd_latch), 32'(exp_latch));
         chk("snd_stb",   32'(bus.snd_stb),   32'(exp_stb));
         chk("main_flag", 32'(bus.main_flag), 32'(exp_flag));
         chk("irq_n",     32'(bus.irq_n),     32'(exp_irq_n));
         chk("rstn",      32'(bus.rstn),      32'(m_rstn));
      end
   end

   initial forever begin
      @(negedge clk);
      if (bus.snd_stb) stb_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d, input int hold);
      @(negedge clk);
      bus.cs = 1; bus.wr_n = 0; bus.addr = a; bus.cpu_dout = d;
      repeat (hold) @(negedge clk);
      bus.cs = 0; bus.wr_n = 1;
   endtask

   task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.cs = 1; bus.rd_n = 0; bus.addr = a;
      @(negedge clk);
      d = bus.dout;
      bus.cs = 0; bus.rd_n = 1;
   endtask

   task automatic reply(input logic [7:0] d, input int n);
      @(negedge clk);
      bus.main_latch = d; bus.main_stb = 1;
      repeat (n) @(negedge clk);
      bus.main_stb = 0;
      @(negedge clk);
   endtask

   task automatic wait_rstn(output int cnt);
      cnt = 0;
      while (!bus.rstn && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   logic [7:0] rd;
   int cnt, mode;

   initial begin
      bus.cen = 1; bus.cs = 0; bus.addr = 0; bus.wr_n = 1; bus.rd_n = 1;
      bus.cpu_dout = 0; bus.snd_flag = 1; bus.main_latch = 0; bus.main_stb = 0;
      repeat (3) @(negedge clk);
      chk("rst_dout",  32'(bus.dout),      32'h0ff);
      chk("rst_latch", 32'(bus.snd_latch), 32'h000);
      chk("rst_rstn",  32'(bus.rstn),      32'h0);
      chk("rst_irq_n", 32'(bus.irq_n),     32'h1);
      rst = 0;
      chk_en = 1;

      // Release: rstn rises after exactly RST_HOLD cen cycles
      idle(2);
      cpu_wr(SNDIF_RST, 8'h01, 1);
      wait_rstn(cnt);
      chk("release_cycles", 32'(cnt), 32'(RST_HOLD));

      // Long write strobe gives a single command pulse
      idle(2);
      stb_cnt = 0;
      cpu_wr(SNDIF_CMD, 8'h5a, 4);
      idle(3);
      chk("cmd_pulses", 32'(stb_cnt), 32'd1);
      chk("cmd_latch", 32'(bus.snd_latch), 32'h5a);

      // Reply capture with IRQ enabled
      cpu_wr(SNDIF_IRQ, 8'h01, 1);
      reply(8'h33, 3);
      chk("reply_flag", 32'(bus.main_flag), 32'h1);
      chk("reply_irq_n", 32'(bus.irq_n), 32'h0);
      cpu_rd(SNDIF_CMD, rd);
      chk("reply_rd", 32'(rd), 32'h33);
      chk("reply_flag_clr", 32'(bus.main_flag), 32'h0);
      cpu_rd(SNDIF_CMD, rd);
      chk("reply_rd_empty", 32'(rd), 32'hff);

      // Overflow behaviour
`ifdef JTBUBL_SNDFIFO_EN
      reply(8'h11, 1); reply(8'h22, 1); reply(8'h33, 1); reply(8'h44, 1); reply(8'h55, 1);
      cpu_rd(SNDIF_STAT, rd);
      chk("ovf_stat", 32'(rd), 32'hfd);
      cpu_rd(SNDIF_CMD, rd); chk("fifo_rd0", 32'(rd), 32'h11);
      cpu_rd(SNDIF_CMD, rd); chk("fifo_rd1", 32'(rd), 32'h22);
      cpu_rd(SNDIF_CMD, rd); chk("fifo_rd2", 32'(rd), 32'h33);
      cpu_rd(SNDIF_CMD, rd); chk("fifo_rd3", 32'(rd), 32'h44);
      cpu_rd(SNDIF_CMD, rd); chk("fifo_rd4", 32'(rd), 32'hff);
`else
      reply(8'haa, 1); reply(8'hbb, 1);
      cpu_rd(SNDIF_CMD, rd);
      chk("ovw_rd", 32'(rd), 32'hbb);
      cpu_rd(SNDIF_STAT, rd);
      chk("ovf_stat", 32'(rd), 32'hfc);
`endif
      cpu_rd(SNDIF_STAT, rd);
      chk("ovf_cleared", 32'(rd), 32'h7c);

      // Push and pop on the same clock
      reply(8'h11, 1);
      @(negedge clk);
      bus.cs = 1; bus.rd_n = 0; bus.addr = SNDIF_CMD; bus.main_latch = 8'h77; bus.main_stb = 1;
      @(negedge clk);
      chk("same_clk_rd", 32'(bus.dout), 32'h11);
      chk("same_clk_flag", 32'(bus.main_flag), 32'h1);
      bus.cs = 0; bus.rd_n = 1; bus.main_stb = 0;
      cpu_rd(SNDIF_CMD, rd);
      chk("same_clk_kept", 32'(rd), 32'h77);

      // Hold while a reply is pending flushes it and blocks new ones
      reply(8'h42, 1);
      chk("pend_flag", 32'(bus.main_flag), 32'h1);
      cpu_wr(SNDIF_RST, 8'h00, 1);
      chk("hold_rstn", 32'(bus.rstn), 32'h0);
      chk("hold_flush", 32'(bus.main_flag), 32'h0);
      reply(8'h99, 1);
      chk("hold_ignore", 32'(bus.main_flag), 32'h0);
      cpu_wr(SNDIF_RST, 8'h01, 1);
      wait_rstn(cnt);
      chk("rerelease_cycles", 32'(cnt), 32'(RST_HOLD));
      chk("rerelease_flag", 32'(bus.main_flag), 32'h0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         bus.cen = ($urandom_range(3) != 0);
         bus.cs = 1'($urandom_range(1));
         mode = int'($urandom_range(3));
         bus.wr_n = (mode != 0);
         bus.rd_n = (mode != 1);
         bus.addr = 2'($urandom_range(3));
         bus.cpu_dout = 8'($urandom);
         if (bus.addr == SNDIF_RST) bus.cpu_dout[0] = ($urandom_range(15) != 0);
         bus.main_latch = 8'($urandom);
         bus.main_stb = ($urandom_range(2) == 0);
         bus.snd_flag = 1'($urandom_range(1));
      end
      @(negedge clk);
      bus.cs = 0; bus.wr_n = 1; bus.rd_n = 1; bus.main_stb = 0; bus.cen = 1;
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
